uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver; downstream partner of uart_tx, consuming its serial tx line.
//  Oversamples rx on the system clock, locates bit centres from the start-bit edge,
//  deserialises LSB-first and presents a byte with a one-cycle valid strobe.
//  Drives data_out of the UART top-level, closing the tx->rx loopback path.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency in Hz
//  BAUD_RATE   2400        line rate in bit/s; must match the transmitter
//  OVERSAMPLE  16          sample ticks per bit; even, >= 8
//  DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated; default is 1302 clk per tick
// PORTS
//  clk        in   1  system clock, rising edge
//  srst       in   1  synchronous reset, active-high
//  rx         in   1  serial input, idle high; asynchronous to clk
//  data_out   out  8  last correctly framed byte; held until the next good byte
//  valid      out  1  one-clk pulse: data_out was just updated
//  frame_err  out  1  one-clk pulse: stop bit sampled low, byte discarded
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset: data_out=8'h00, valid=0, frame_err=0, busy=0, FSM=IDLE, sync FFs=1, counters=0.
//  - rx passes through a 2-FF synchroniser (reset value 1). All decisions use rx_s,
//    the second flop output.
//  - Tick counter: counts 0..DIV-1, and tick=1 for one clk when it wraps.
//    The counter is cleared whenever the FSM is in IDLE, so the first tick falls DIV clk after the start edge.
//  - The FSM keeps a sample counter scnt (0..OVERSAMPLE-1) and a bit index bcnt (0..7).
//    IDLE  : rx_s==0 -> START, with scnt=0 and busy=1.
//    START : on the tick where scnt reaches OVERSAMPLE/2-1 (the mid-start point), sample rx_s.
//            If rx_s==0 -> DATA, with scnt=0 and bcnt=0.
//            If rx_s==1 -> IDLE. This is a glitch or false start; no strobe is raised.
//    DATA  : each time scnt wraps at OVERSAMPLE-1, shift rx_s into shreg[7] (LSB first,
//            right shift). After bcnt==7 -> STOP (or PARITY; see below).
//    STOP  : at the mid-stop point, sample rx_s.
//            If rx_s==1, data_out<=shreg and valid=1.
//            If rx_s==0, frame_err=1 and data_out is unchanged.
//            In both cases go -> IDLE in the same cycle. Returning at mid-stop allows back-to-back frames.
//  - valid and frame_err are never high together, and each is high for exactly one clk.
//  - Latency: valid rises about 9.5 bit times + 3 clk after the falling edge of rx.
//  - Line held low (break): a frame_err pulse follows. IDLE then re-enters START at once,
//    and each later frame gets another frame_err, because the stop bit samples low.
//  - srst asserted mid-frame: return to the reset state on the next edge. The partial byte
//    is lost and no strobe is raised.
//  - An rx edge arriving while busy is ignored. Resynchronisation happens only in IDLE.
// CONFIGURATION
//  `UART_RX_PARITY_EN defined:
//    - Frame is 8E1. The FSM adds a PARITY state between DATA and STOP.
//    - In PARITY, the bit is sampled at mid-bit and must equal ^shreg (even parity).
//    - Output parity_err (1 bit) pulses for one clk at the stop sample of a parity-failing frame.
//      In that case valid=0 and data_out is unchanged.
//    - If both parity and stop fail, only frame_err pulses.
//  Not defined:
//    - Frame is 8N1. There is no PARITY state and the parity_err port does not exist.
// TESTING (CLK_FREQ=160_000, BAUD_RATE=1000, OVERSAMPLE=16 -> DIV=10, 1 bit = 160 clk)
//  1. Drive 8'hA5 as 8N1 -> one valid pulse, data_out==8'hA5, frame_err stays 0,
//     busy drops in the same cycle as valid.
//  2. Send 8'h00 then 8'hFF back-to-back with a zero-length idle gap -> two valid pulses,
//     data_out 8'h00 then 8'hFF.
//  3. Drive rx low for 40 clk, then high -> FSM returns to IDLE, with no valid and no frame_err.
//  4. Send 8'h3C with the stop bit forced low -> frame_err pulses once, valid stays 0,
//     data_out keeps its previous value.
//  5. Assert srst for 1 clk at the middle of data bit 4, then send 8'h5A -> no strobe for
//     the aborted frame, then valid with data_out==8'h5A.
//  6. With UART_RX_PARITY_EN defined:
//     - 8'h81 with parity 0 -> valid, data_out==8'h81.
//     - 8'h81 with parity 1 -> parity_err pulses, valid stays 0.
//  Loopback: UART top-level with uart_tx on tx and uart_rx on rx. Random bytes must match
//  end to end, and valid must fire once per uart_tx frame.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with oversampled bit-centre detection.
// A 2-FF synchroniser conditions rx. A tick divider paces the sample counter,
// and an FSM finds the start-bit centre and then samples every data bit at its middle.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined the frame is 8E1,
// with a PARITY state and a parity_err strobe.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 2400,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [SW-1:0] scnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  // Two-flop synchroniser for the asynchronous serial line. It resets to the idle level.
  always_ff @(posedge clk) begin
    if (srst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The oversample tick fires once every DIV clocks. It is held at zero while idle,
  // so the phase of each frame is taken from its own start edge.
  assign tick = (state != IDLE) && (tcnt == TICK_LAST);

  // Tick divider. Clearing it in IDLE realigns the sample phase on every start edge.
  always_ff @(posedge clk) begin
    if (srst || state == IDLE || tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Frame FSM: start qualification, LSB-first deserialisation, stop check and strobes.
  always_ff @(posedge clk) begin
    valid     <= 1'b0;
    frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err <= 1'b0;
`endif
    if (srst) begin
      state    <= IDLE;
      scnt     <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      data_out <= 8'h00;
      busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            scnt  <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (scnt == SCNT_MID) begin
              if (!rx_s) begin
                state <= DATA;
                scnt  <= '0;
                bcnt  <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (scnt == SCNT_LAST) begin
              scnt  <= '0;
              shreg <= {rx_s, shreg[7:1]};
              if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (scnt == SCNT_LAST) begin
              scnt    <= '0;
              par_bad <= (rx_s != ^shreg);
              state   <= STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (scnt == SCNT_LAST) begin
              scnt  <= '0;
              state <= IDLE;
              busy  <= 1'b0;
              if (!rx_s) begin
                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad) begin
                parity_err <= 1'b1;
`endif
              end else begin
                data_out <= shreg;
                valid    <= 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
